ifq_issue: RTL and testbench

- Consumer end of the instruction fetch queue.
- Pops instruction words from the fetch FIFO and buffers them in a 2-entry output buffer.
- Presents instructions with their PC to decode using a valid/ready handshake.
- On a taken branch, discards all held or in-flight words, flushes the FIFO and issues a redirect to the fetch side.

---
 rtl/ifq_pkg.sv | 14 +
 rtl/ifq_issue_if.sv | 34 +++
 rtl/ifq_skid_buf.sv | 60 ++++++
 rtl/ifq_issue.sv | 110 +++++++++++
 tb/tb_ifq_issue.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ifq_pkg.sv
// Shared types and sizing for the instruction-fetch-queue issue stage.
package ifq_pkg;

  typedef enum logic [1:0] {
    RST   = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } ifq_issue_state_t;

  localparam int IFQ_INST_W = 32;
  localparam int IFQ_PC_W   = 32;
  localparam int BUF_DEPTH  = 2;

endpackage

// File: rtl/ifq_issue_if.sv
// Fetch-FIFO, decode and redirect signals of the issue stage; master = issue stage.
interface ifq_issue_if
  import ifq_pkg::*;
#(
  parameter int INST_W = IFQ_INST_W,
  parameter int PC_W   = IFQ_PC_W
);

  logic              fifo_empty;
  logic [INST_W-1:0] fifo_dout;
  logic              pop_fifo;
  logic              flush_fifo;
  logic              inst_valid;
  logic [INST_W-1:0] inst_data;
  logic [PC_W-1:0]   inst_pc;
  logic              decode_ready;
  logic              branch_valid;
  logic [PC_W-1:0]   branch_target;
  logic              redirect_valid;
  logic [PC_W-1:0]   redirect_pc;

  modport master (
    input  fifo_empty, fifo_dout, decode_ready, branch_valid, branch_target,
    output pop_fifo, flush_fifo, inst_valid, inst_data, inst_pc,
           redirect_valid, redirect_pc
  );

  modport slave (
    output fifo_empty, fifo_dout, decode_ready, branch_valid, branch_target,
    input  pop_fifo, flush_fifo, inst_valid, inst_data, inst_pc,
           redirect_valid, redirect_pc
  );

endinterface

// File: rtl/ifq_skid_buf.sv
// Two-entry FIFO of {instruction, pc} between the fetch FIFO read port and decode.
module ifq_skid_buf
  import ifq_pkg::*;
#(
  parameter int INST_W = IFQ_INST_W,
  parameter int PC_W   = IFQ_PC_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              wr,
  input  logic [INST_W-1:0] wr_inst,
  input  logic [PC_W-1:0]   wr_pc,
  input  logic              rd,
  output logic [INST_W-1:0] rd_inst,
  output logic [PC_W-1:0]   rd_pc,
  output logic [1:0]        count
);

  localparam logic [1:0] FULL = 2'(BUF_DEPTH);

  logic [INST_W-1:0] inst_mem [BUF_DEPTH];
  logic [PC_W-1:0]   pc_mem   [BUF_DEPTH];
  // Single-bit pointers: the buffer is exactly two entries deep.
  logic              wr_ptr;
  logic              rd_ptr;
  logic              do_wr;
  logic              do_rd;

  assign do_rd = rd && (count != 2'd0);
  assign do_wr = wr && ((count < FULL) || do_rd);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (clr) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_wr) wr_ptr <= ~wr_ptr;
      if (do_rd) rd_ptr <= ~rd_ptr;
      if (do_wr && !do_rd)      count <= count + 2'd1;
      else if (!do_wr && do_rd) count <= count - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) begin
      inst_mem[wr_ptr] <= wr_inst;
      pc_mem[wr_ptr]   <= wr_pc;
    end
  end

  assign rd_inst = inst_mem[rd_ptr];
  assign rd_pc   = pc_mem[rd_ptr];

endmodule

// File: rtl/ifq_issue.sv
// Issue stage: pops the fetch FIFO into a 2-entry buffer, hands words to decode
// with their PC, and on a taken branch drops everything and redirects fetch.
module ifq_issue
  import ifq_pkg::*;
#(
  parameter int              INST_W   = IFQ_INST_W,
  parameter int              PC_W     = IFQ_PC_W,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              PC_STEP  = 4
) (
  input  logic       clk,
  input  logic       reset,
  ifq_issue_if.master bus
);

  ifq_issue_state_t  state_q;
  ifq_issue_state_t  state_d;
  logic              run;
  logic              in_flush;
  logic              flush_now;
  logic              inflight_p1;
  logic              capture;
  logic              deq;
  logic              pop;
  logic              inst_valid;
  logic [2:0]        credit;
  logic [1:0]        count;
  logic [PC_W-1:0]   pc_q;
  logic [PC_W-1:0]   wr_pc;
  logic [INST_W-1:0] head_inst;
  logic [PC_W-1:0]   head_pc;

  function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] t);
    return t & ~PC_W'(3);
  endfunction

  function automatic logic [PC_W-1:0] step_pc(input logic [PC_W-1:0] p);
    return p + PC_W'(PC_STEP);
  endfunction

  always_comb begin
    state_d  = RST;
    run      = 1'b0;
    in_flush = 1'b0;
    case (state_q)
      RST:   state_d = RUN;
      RUN: begin
        run     = 1'b1;
        state_d = bus.branch_valid ? FLUSH : RUN;
      end
      FLUSH: begin
        in_flush = 1'b1;
        state_d  = bus.branch_valid ? FLUSH : RUN;
      end
      default: state_d = RST;
    endcase
  end

  assign flush_now  = (run || in_flush) && bus.branch_valid;
  assign inst_valid = run && (count != 2'd0) && !bus.branch_valid;
  assign deq        = inst_valid && bus.decode_ready;
  assign capture    = inflight_p1 && !flush_now;

  // Buffered words plus the word in flight never exceed the buffer depth.
  assign credit = {1'b0, count} + {2'b00, inflight_p1} - {2'b00, deq};
  assign pop    = run && !bus.fifo_empty && !bus.branch_valid && (credit < 3'd2);

  // A capture only happens with at most one word ahead of it, so the tail pc
  // is either the head pc or the one after it.
  assign wr_pc = (count == 2'd0) ? pc_q : step_pc(pc_q);

  // Stage p0 -> p1: FIFO read issued, data returns on the next edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RST;
      inflight_p1 <= 1'b0;
      pc_q        <= RESET_PC;
    end else begin
      state_q     <= state_d;
      inflight_p1 <= pop;
      if (flush_now)  pc_q <= align_pc(bus.branch_target);
      else if (deq)   pc_q <= step_pc(pc_q);
    end
  end

  ifq_skid_buf #(
    .INST_W (INST_W),
    .PC_W   (PC_W)
  ) u_buf (
    .clk     (clk),
    .reset   (reset),
    .clr     (flush_now),
    .wr      (capture),
    .wr_inst (bus.fifo_dout),
    .wr_pc   (wr_pc),
    .rd      (deq),
    .rd_inst (head_inst),
    .rd_pc   (head_pc),
    .count   (count)
  );

  assign bus.pop_fifo       = pop;
  assign bus.flush_fifo     = in_flush;
  assign bus.inst_valid     = inst_valid;
  assign bus.inst_data      = inst_valid ? head_inst : '0;
  assign bus.inst_pc        = inst_valid ? head_pc : '0;
  assign bus.redirect_valid = in_flush;
  assign bus.redirect_pc    = in_flush ? pc_q : '0;

endmodule

// File: tb/tb_ifq_issue.sv
// Scoreboard bench for ifq_issue: a fetch-FIFO model feeds the DUT, a monitor
// checks every issued word and every redirect against queued expectations.
module tb_ifq_issue;

  typedef struct {
    logic [31:0] data;
    logic [31:0] pc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ifq_issue_if #(.INST_W(32), .PC_W(32)) bus ();
  ifq_issue_if #(.INST_W(32), .PC_W(8))  bus8 ();

  ifq_issue #(.INST_W(32), .PC_W(32), .RESET_PC(32'h0), .PC_STEP(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  ifq_issue #(.INST_W(32), .PC_W(8), .RESET_PC(8'hFC), .PC_STEP(4)) dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus8)
  );

  exp_t        exp_q[$];
  logic [31:0] redir_q[$];
  logic [31:0] fq[$];
  int          checks = 0;
  int          errors = 0;
  int          npop = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // One clock of the fetch-FIFO model; returns just after the rising edge.
  task automatic step();
    logic p, f;
    @(negedge clk);
    p = bus.pop_fifo;
    f = bus.flush_fifo;
    @(posedge clk);
    #1;
    if (f) fq.delete();
    if (p) begin
      npop++;
      if (fq.size() != 0) bus.fifo_dout = fq.pop_front();
    end
    bus.fifo_empty = (fq.size() == 0);
  endtask

  task automatic feed(input logic [31:0] w);
    fq.push_back(w);
    bus.fifo_empty = 1'b0;
  endtask

  task automatic expect_issue(input logic [31:0] w, input logic [31:0] pc);
    exp_t e;
    e.data = w;
    e.pc   = pc;
    exp_q.push_back(e);
  endtask

  // Monitor: compares every transfer and redirect at the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.inst_valid && bus.decode_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_issue: got data %h pc %h, expected no transfer",
                   bus.inst_data, bus.inst_pc);
        end else begin
          e = exp_q.pop_front();
          check("issue_data", bus.inst_data, e.data);
          check("issue_pc", bus.inst_pc, e.pc);
        end
      end
      if (bus.redirect_valid) begin
        if (redir_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_redirect: got pc %h, expected no redirect", bus.redirect_pc);
        end else begin
          check("redirect_pc", bus.redirect_pc, redir_q.pop_front());
        end
        check("flush_with_redirect", {31'b0, bus.flush_fifo}, 32'd1);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got time limit, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic found;
    bus.fifo_empty    = 1'b1;
    bus.fifo_dout     = '0;
    bus.decode_ready  = 1'b0;
    bus.branch_valid  = 1'b0;
    bus.branch_target = '0;
    bus8.fifo_empty    = 1'b1;
    bus8.fifo_dout     = 32'h55;
    bus8.decode_ready  = 1'b1;
    bus8.branch_valid  = 1'b0;
    bus8.branch_target = '0;

    // Reset state
    reset = 1'b1;
    repeat (2) step();
    #1;
    check("rst_pop", {31'b0, bus.pop_fifo}, 32'd0);
    check("rst_flush", {31'b0, bus.flush_fifo}, 32'd0);
    check("rst_valid", {31'b0, bus.inst_valid}, 32'd0);
    check("rst_data", bus.inst_data, 32'h0);
    check("rst_pc", bus.inst_pc, 32'h0);
    check("rst_redir_valid", {31'b0, bus.redirect_valid}, 32'd0);
    check("rst_redir_pc", bus.redirect_pc, 32'h0);
    check("rst_pc8", {24'b0, bus8.inst_pc}, 32'h0);

    reset = 1'b0;
    step();
    #1;
    check("idle_pop", {31'b0, bus.pop_fifo}, 32'd0);
    step();
    #1;
    check("idle_pop2", {31'b0, bus.pop_fifo}, 32'd0);
    check("idle_valid", {31'b0, bus.inst_valid}, 32'd0);

    // Streaming at one word per cycle
    npop = 0;
    for (int i = 0; i < 3; i++) begin
      feed(32'hA0 + i);
      expect_issue(32'hA0 + i, 32'h0 + 4 * i);
    end
    bus.decode_ready = 1'b1;
    #1;
    check("stream_pop_c0", {31'b0, bus.pop_fifo}, 32'd1);
    step();
    #1;
    check("stream_valid_c1", {31'b0, bus.inst_valid}, 32'd0);
    step();
    #1;
    check("stream_valid_c2", {31'b0, bus.inst_valid}, 32'd1);
    check("stream_first_pc", bus.inst_pc, 32'h0);
    step();
    check("stream_pops_3cyc", npop, 3);
    repeat (3) step();
    #1;
    check("stream_pops_total", npop, 3);
    check("stream_drained", {31'b0, bus.inst_valid}, 32'd0);

    // Backpressure: buffer fills to two, then drains in order
    bus.decode_ready = 1'b0;
    npop = 0;
    for (int i = 0; i < 5; i++) begin
      feed(32'hA0 + i);
      expect_issue(32'hA0 + i, 32'hC + 4 * i);
    end
    repeat (6) step();
    #1;
    check("bp_pops", npop, 2);
    check("bp_valid", {31'b0, bus.inst_valid}, 32'd1);
    check("bp_head_data", bus.inst_data, 32'hA0);
    check("bp_head_pc", bus.inst_pc, 32'hC);
    bus.decode_ready = 1'b1;
    repeat (8) step();
    #1;
    check("bp_pops_total", npop, 5);
    check("bp_drained", {31'b0, bus.inst_valid}, 32'd0);

    // Branch with one word buffered and one in flight
    for (int i = 0; i < 6; i++) feed(32'hC0 + i);
    expect_issue(32'hC0, 32'h20);
    repeat (3) step();
    bus.branch_valid  = 1'b1;
    bus.branch_target = 32'h103;
    redir_q.push_back(32'h100);
    #1;
    check("br_valid_low", {31'b0, bus.inst_valid}, 32'd0);
    check("br_pop_low", {31'b0, bus.pop_fifo}, 32'd0);
    step();
    bus.branch_valid = 1'b0;
    #1;
    check("br_flush", {31'b0, bus.flush_fifo}, 32'd1);
    check("br_redir_valid", {31'b0, bus.redirect_valid}, 32'd1);
    check("br_redir_pc", bus.redirect_pc, 32'h100);
    check("br_flush_valid_low", {31'b0, bus.inst_valid}, 32'd0);
    step();
    feed(32'hD0);
    expect_issue(32'hD0, 32'h100);
    repeat (5) step();

    // Back-to-back branches: second one lands while in FLUSH
    bus.branch_valid  = 1'b1;
    bus.branch_target = 32'h200;
    redir_q.push_back(32'h200);
    step();
    bus.branch_target = 32'h300;
    redir_q.push_back(32'h300);
    step();
    bus.branch_valid = 1'b0;
    #1;
    check("b2b_redir_valid", {31'b0, bus.redirect_valid}, 32'd1);
    check("b2b_redir_pc", bus.redirect_pc, 32'h300);
    step();
    #1;
    check("b2b_resume_redir", {31'b0, bus.redirect_valid}, 32'd0);
    feed(32'hE0);
    expect_issue(32'hE0, 32'h300);
    repeat (5) step();

    // Reset while in FLUSH
    bus.branch_valid  = 1'b1;
    bus.branch_target = 32'h400;
    step();
    bus.branch_valid = 1'b0;
    #1;
    check("rf_in_flush", {31'b0, bus.redirect_valid}, 32'd1);
    reset = 1'b1;
    #1;
    check("rf_redir_valid", {31'b0, bus.redirect_valid}, 32'd0);
    check("rf_flush", {31'b0, bus.flush_fifo}, 32'd0);
    check("rf_redir_pc", bus.redirect_pc, 32'h0);
    repeat (2) step();
    reset = 1'b0;
    step();
    feed(32'hF0);
    expect_issue(32'hF0, 32'h0);
    repeat (5) step();

    // PC wrap on the 8-bit instance starting at 0xFC
    bus8.fifo_empty = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      #1;
      if (bus8.inst_valid) found = 1'b1;
    end
    check("wrap_first_valid", {31'b0, found}, 32'd1);
    if (found) begin
      check("wrap_pc_fc", {24'b0, bus8.inst_pc}, 32'hFC);
      check("wrap_data", bus8.inst_data, 32'h55);
      step();
      #1;
      check("wrap_valid_next", {31'b0, bus8.inst_valid}, 32'd1);
      check("wrap_pc_00", {24'b0, bus8.inst_pc}, 32'h00);
    end
    bus8.fifo_empty = 1'b1;
    repeat (3) step();

    check("scoreboard_drained", exp_q.size(), 0);
    check("redirects_drained", redir_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
